// File: rtl/nco_multiwave.sv
// Multi-waveform NCO: phase accumulator with shadowed config applied at phase wrap,
// output phase offset, four waveform shapes and a linear frequency-sweep engine.
module nco_multiwave #(
  parameter int unsigned PHASE_W     = 32,
  parameter int unsigned OUT_W       = 12,
  parameter int unsigned SWEEP_DIV_W = 16
) (
  input  logic                   sys_clk,
  input  logic                   n_rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_W-1:0]     cfg_step,
  input  logic [PHASE_W-1:0]     cfg_offset,
  input  logic [1:0]             cfg_wave,
  input  logic [OUT_W-1:0]       cfg_duty,
  input  logic                   cfg_sweep,
  input  logic [PHASE_W-1:0]     cfg_delta,
  input  logic [PHASE_W-1:0]     cfg_stop,
  input  logic [SWEEP_DIV_W-1:0] cfg_div,
  output logic [OUT_W-1:0]       o_wave,
  output logic                   o_clk,
  output logic                   o_wrap,
  output logic                   sweep_done
);

  typedef enum logic [1:0] {StIdle, StRun, StPend, StSweep} state_e;

  state_e state_q, state_d;

  logic [PHASE_W-1:0]     phase_q, phase_d;
  logic [PHASE_W-1:0]     step_q, step_d;
  logic [PHASE_W-1:0]     offset_q, offset_d;
  logic [1:0]             wave_q, wave_d;
  logic [OUT_W-1:0]       duty_q, duty_d;
  logic [PHASE_W-1:0]     delta_q, delta_d;
  logic [PHASE_W-1:0]     stop_q, stop_d;
  logic [SWEEP_DIV_W-1:0] div_q, div_d;
  logic [SWEEP_DIV_W-1:0] cnt_q, cnt_d;
  logic                   from_idle_q, from_idle_d;

  logic [PHASE_W-1:0]     sh_step_q, sh_step_d;
  logic [PHASE_W-1:0]     sh_offset_q, sh_offset_d;
  logic [1:0]             sh_wave_q, sh_wave_d;
  logic [OUT_W-1:0]       sh_duty_q, sh_duty_d;
  logic                   sh_sweep_q, sh_sweep_d;
  logic [PHASE_W-1:0]     sh_delta_q, sh_delta_d;
  logic [PHASE_W-1:0]     sh_stop_q, sh_stop_d;
  logic [SWEEP_DIV_W-1:0] sh_div_q, sh_div_d;

  logic [OUT_W-1:0]       o_wave_q, o_wave_d;
  logic                   o_clk_q, o_clk_d;
  logic                   o_wrap_q;
  logic                   done_q, done_d;

  logic                   transfer;
  logic                   apply;
  logic                   carry;
  logic [PHASE_W:0]       acc_sum;
  logic [PHASE_W:0]       sweep_sum;
  logic                   sweep_hit;
  logic                   start_clamp;
  logic [PHASE_W-1:0]     phase_off;
  logic [OUT_W-1:0]       p;
  logic [OUT_W-1:0]       t;
  logic                   m;

  assign transfer    = cfg_valid & cfg_ready;
  assign acc_sum     = {1'b0, phase_q} + {1'b0, step_q};
  assign carry       = acc_sum[PHASE_W];
  assign apply       = (state_q == StPend) & (from_idle_q | carry);
  assign sweep_sum   = {1'b0, step_q} + {1'b0, delta_q};
  assign sweep_hit   = sweep_sum[PHASE_W] | (sweep_sum[PHASE_W-1:0] >= stop_q);
  assign start_clamp = sh_step_q >= sh_stop_q;

  // State register
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (transfer) state_d = StPend;
      end
      StSweep: begin
        if (transfer) begin
          state_d = StPend;
        end else if ((cnt_q == '0) && sweep_hit) begin
          state_d = StRun;
        end
      end
      StPend: begin
        if (apply) begin
          if (sh_step_q == '0) begin
            state_d = StIdle;
          end else if (sh_sweep_q) begin
            // A start step already past the stop clamps; a zero stop leaves no motion.
            if (start_clamp) begin
              state_d = (sh_stop_q == '0) ? StIdle : StRun;
            end else begin
              state_d = StSweep;
            end
          end else begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cfg_ready = (state_q != StPend);
  end

  // Accumulator, shadow capture, apply and sweep arithmetic
  always_comb begin
    phase_d     = acc_sum[PHASE_W-1:0];
    step_d      = step_q;
    offset_d    = offset_q;
    wave_d      = wave_q;
    duty_d      = duty_q;
    delta_d     = delta_q;
    stop_d      = stop_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    from_idle_d = from_idle_q;
    sh_step_d   = sh_step_q;
    sh_offset_d = sh_offset_q;
    sh_wave_d   = sh_wave_q;
    sh_duty_d   = sh_duty_q;
    sh_sweep_d  = sh_sweep_q;
    sh_delta_d  = sh_delta_q;
    sh_stop_d   = sh_stop_q;
    sh_div_d    = sh_div_q;
    done_d      = 1'b0;

    if (transfer) begin
      sh_step_d   = cfg_step;
      sh_offset_d = cfg_offset;
      sh_wave_d   = cfg_wave;
      sh_duty_d   = cfg_duty;
      sh_sweep_d  = cfg_sweep;
      sh_delta_d  = cfg_delta;
      sh_stop_d   = cfg_stop;
      sh_div_d    = cfg_div;
      from_idle_d = (state_q == StIdle);
    end

    if (apply) begin
      step_d   = (sh_sweep_q && start_clamp) ? sh_stop_q : sh_step_q;
      offset_d = sh_offset_q;
      wave_d   = sh_wave_q;
      duty_d   = sh_duty_q;
      delta_d  = sh_delta_q;
      stop_d   = sh_stop_q;
      div_d    = sh_div_q;
      cnt_d    = sh_div_q;
      done_d   = sh_sweep_q & start_clamp & (sh_step_q != '0);
    end else if ((state_q == StSweep) && !transfer) begin
      if (cnt_q == '0) begin
        cnt_d = div_q;
        if (sweep_hit) begin
          step_d = stop_q;
          done_d = 1'b1;
        end else begin
          step_d = sweep_sum[PHASE_W-1:0];
        end
      end else begin
        cnt_d = cnt_q - SWEEP_DIV_W'(1);
      end
    end
  end

  // Waveform shaping from the offset phase
  always_comb begin
    phase_off = phase_q + offset_q;
    p         = OUT_W'(phase_off >> (PHASE_W - OUT_W));
    m         = p[OUT_W-1];
    t         = {p[OUT_W-2:0], 1'b0};
    o_clk_d   = m;
    o_wave_d  = '0;
    unique case (wave_q)
      2'd0:    o_wave_d = {OUT_W{m}};
      2'd1:    o_wave_d = p;
      2'd2:    o_wave_d = m ? ~t : t;
      default: o_wave_d = (p < duty_q) ? {OUT_W{1'b1}} : '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q     <= '0;
      step_q      <= '0;
      offset_q    <= '0;
      wave_q      <= '0;
      duty_q      <= '0;
      delta_q     <= '0;
      stop_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      from_idle_q <= 1'b0;
      sh_step_q   <= '0;
      sh_offset_q <= '0;
      sh_wave_q   <= '0;
      sh_duty_q   <= '0;
      sh_sweep_q  <= 1'b0;
      sh_delta_q  <= '0;
      sh_stop_q   <= '0;
      sh_div_q    <= '0;
      o_wave_q    <= '0;
      o_clk_q     <= 1'b0;
      o_wrap_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      step_q      <= step_d;
      offset_q    <= offset_d;
      wave_q      <= wave_d;
      duty_q      <= duty_d;
      delta_q     <= delta_d;
      stop_q      <= stop_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      from_idle_q <= from_idle_d;
      sh_step_q   <= sh_step_d;
      sh_offset_q <= sh_offset_d;
      sh_wave_q   <= sh_wave_d;
      sh_duty_q   <= sh_duty_d;
      sh_sweep_q  <= sh_sweep_d;
      sh_delta_q  <= sh_delta_d;
      sh_stop_q   <= sh_stop_d;
      sh_div_q    <= sh_div_d;
      o_wave_q    <= o_wave_d;
      o_clk_q     <= o_clk_d;
      o_wrap_q    <= carry;
      done_q      <= done_d;
    end
  end

  assign o_wave     = o_wave_q;
  assign o_clk      = o_clk_q;
  assign o_wrap     = o_wrap_q;
  assign sweep_done = done_q;

endmodule
